// File: rtl/adsr_envelope.sv
// ADSR envelope generator: a tick-paced level FSM scales an incoming
// waveform sample. Gate edges act immediately and take priority over tick updates.
module adsr_envelope #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] attack_step,
  input  logic [7:0] decay_step,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_step,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic [7:0] env_level,
  output logic [2:0] state,
  output logic       active
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      level_q, level_d;
  logic [7:0]      sample_q, sample_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gate_q;
  logic            rise, fall, tick;
  logic [8:0]      attack_sum;
  logic [8:0]      decay_floor;
  logic [15:0]     product;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign tick = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  // Widened to 9 bits so the clamp tests see the true sum, never a wrapped one.
  assign attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  assign product  = {8'd0, sample_in} * {8'd0, level_q};
  assign sample_d = product[15:8];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ST_ATTACK;
    end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                          state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_IDLE: level_d = 8'd0;
        ST_ATTACK: if (tick) begin
          if (attack_sum >= 9'd255 || attack_step == 8'd0) begin
            level_d = 8'd255;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[7:0];
          end
        end
        ST_DECAY: if (tick) begin
          if ({1'b0, level_q} <= decay_floor || decay_step == 8'd0) begin
            level_d = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - decay_step;
          end
        end
        ST_SUSTAIN: if (tick) level_d = sustain_level;
        ST_RELEASE: if (tick) begin
          if (level_q <= release_step || release_step == 8'd0) begin
            level_d = 8'd0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - release_step;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      level_q  <= 8'd0;
      sample_q <= 8'd0;
      cnt_q    <= '0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate;
    end
  end

  assign sample_out = sample_q;
  assign env_level  = level_q;
  assign state      = state_q;
  assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: TICK_DIV=4 main instance plus a
// TICK_DIV=1 instance sharing the same stimulus.
module tb_adsr_envelope;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] attack_step = 8'd64, decay_step = 8'd32;
  logic [7:0] sustain_level = 8'd128, release_step = 8'd50;
  logic [7:0] sample_in = 8'd240;
  logic [7:0] so4, lv4, so1, lv1;
  logic [2:0] st4, st1;
  logic       ac4, ac1;
  int checks = 0;
  int failures = 0;

  adsr_envelope #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .gate(gate), .attack_step(attack_step),
    .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .sample_in(sample_in),
    .sample_out(so4), .env_level(lv4), .state(st4), .active(ac4)
  );

  adsr_envelope #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .gate(gate), .attack_step(attack_step),
    .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .sample_in(sample_in),
    .sample_out(so1), .env_level(lv1), .state(st1), .active(ac1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After this returns, the next rising edge is E1; ticks land on E4, E8, ...
  task automatic do_reset(input logic g);
    reset = 1'b1;
    gate  = g;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_params(input logic [7:0] a, d, s, r);
    attack_step = a; decay_step = d; sustain_level = s; release_step = r;
  endtask

  task automatic test_reset;
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    reset = 1'b1;
    gate  = 1'b0;
    cyc(3);
    checks++; if (st4 !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", st4); end
    checks++; if (lv4 !== 8'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", lv4); end
    checks++; if (so4 !== 8'd0) begin failures++; $display("FAIL rst_sample got=%0d exp=0", so4); end
    checks++; if (ac4 !== 1'b0) begin failures++; $display("FAIL rst_active got=%0d exp=0", ac4); end
  endtask

  task automatic test_attack_decay;
    logic [7:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a = '{8'd64, 8'd128, 8'd192, 8'd255};
    exp_d = '{8'd223, 8'd191, 8'd159, 8'd128};
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    sample_in = 8'd240;
    do_reset(1'b1);
    cyc(1);
    checks++; if (st4 !== 3'd1 || lv4 !== 8'd0) begin failures++; $display("FAIL rise_after_reset got=%0d/%0d exp=1/0", st4, lv4); end
    checks++; if (ac4 !== 1'b1) begin failures++; $display("FAIL active_attack got=%0d exp=1", ac4); end
    cyc(2);
    checks++; if (lv4 !== 8'd0) begin failures++; $display("FAIL pre_tick_hold got=%0d exp=0", lv4); end
    for (int i = 0; i < 4; i++) begin
      cyc(i == 0 ? 1 : 4);
      checks++; if (lv4 !== exp_a[i]) begin failures++; $display("FAIL attack_%0d got=%0d exp=%0d", i, lv4, exp_a[i]); end
    end
    checks++; if (st4 !== 3'd2) begin failures++; $display("FAIL enter_decay got=%0d exp=2", st4); end
    cyc(1);
    checks++; if (so4 !== 8'd239) begin failures++; $display("FAIL scale_255 got=%0d exp=239", so4); end
    for (int i = 0; i < 4; i++) begin
      cyc(i == 0 ? 3 : 4);
      checks++; if (lv4 !== exp_d[i]) begin failures++; $display("FAIL decay_%0d got=%0d exp=%0d", i, lv4, exp_d[i]); end
    end
    checks++; if (st4 !== 3'd3) begin failures++; $display("FAIL enter_sustain got=%0d exp=3", st4); end
    cyc(1);
    checks++; if (so4 !== 8'd120) begin failures++; $display("FAIL scale_128 got=%0d exp=120", so4); end
  endtask

  task automatic test_release;
    // Continues from SUSTAIN at 128, one cycle after E32 (now past E33).
    gate = 1'b0;
    cyc(1);
    checks++; if (st4 !== 3'd4 || lv4 !== 8'd128) begin failures++; $display("FAIL enter_release got=%0d/%0d exp=4/128", st4, lv4); end
    cyc(2);
    checks++; if (lv4 !== 8'd78) begin failures++; $display("FAIL release_0 got=%0d exp=78", lv4); end
    cyc(4);
    checks++; if (lv4 !== 8'd28) begin failures++; $display("FAIL release_1 got=%0d exp=28", lv4); end
    cyc(4);
    checks++; if (lv4 !== 8'd0 || st4 !== 3'd0 || ac4 !== 1'b0) begin failures++; $display("FAIL release_end got=%0d/%0d/%0d exp=0/0/0", lv4, st4, ac4); end
    cyc(1);
    checks++; if (so4 !== 8'd0) begin failures++; $display("FAIL scale_0 got=%0d exp=0", so4); end
    cyc(8);
    checks++; if (lv4 !== 8'd0 || st4 !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d/%0d exp=0/0", lv4, st4); end
  endtask

  task automatic test_retrigger;
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    do_reset(1'b1);
    cyc(32);
    checks++; if (st4 !== 3'd3 || lv4 !== 8'd128) begin failures++; $display("FAIL retrig_setup got=%0d/%0d exp=3/128", st4, lv4); end
    gate = 1'b0;
    cyc(4);
    checks++; if (st4 !== 3'd4 || lv4 !== 8'd78) begin failures++; $display("FAIL retrig_rel got=%0d/%0d exp=4/78", st4, lv4); end
    attack_step = 8'd100;
    gate = 1'b1;
    cyc(1);
    checks++; if (st4 !== 3'd1 || lv4 !== 8'd78) begin failures++; $display("FAIL retrig_attack got=%0d/%0d exp=1/78", st4, lv4); end
    cyc(3);
    checks++; if (lv4 !== 8'd178) begin failures++; $display("FAIL retrig_178 got=%0d exp=178", lv4); end
    cyc(4);
    checks++; if (lv4 !== 8'd255 || st4 !== 3'd2) begin failures++; $display("FAIL retrig_255 got=%0d/%0d exp=255/2", lv4, st4); end
  endtask

  task automatic test_edge_priority;
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    do_reset(1'b1);
    cyc(3);
    gate = 1'b0;   // fall coincides with the tick at E4
    cyc(1);
    checks++; if (st4 !== 3'd4 || lv4 !== 8'd0) begin failures++; $display("FAIL fall_over_tick got=%0d/%0d exp=4/0", st4, lv4); end
    cyc(4);
    checks++; if (st4 !== 3'd0) begin failures++; $display("FAIL release_from_0 got=%0d exp=0", st4); end
  endtask

  task automatic test_zero_steps;
    set_params(8'd0, 8'd0, 8'd100, 8'd0);
    do_reset(1'b1);
    cyc(4);
    checks++; if (lv4 !== 8'd255 || st4 !== 3'd2) begin failures++; $display("FAIL zero_attack got=%0d/%0d exp=255/2", lv4, st4); end
    cyc(4);
    checks++; if (lv4 !== 8'd100 || st4 !== 3'd3) begin failures++; $display("FAIL zero_decay got=%0d/%0d exp=100/3", lv4, st4); end
    sustain_level = 8'd90;
    cyc(4);
    checks++; if (lv4 !== 8'd90) begin failures++; $display("FAIL sustain_track got=%0d exp=90", lv4); end
    gate = 1'b0;
    cyc(1);
    checks++; if (st4 !== 3'd4) begin failures++; $display("FAIL zero_rel_enter got=%0d exp=4", st4); end
    cyc(3);
    checks++; if (lv4 !== 8'd0 || st4 !== 3'd0) begin failures++; $display("FAIL zero_release got=%0d/%0d exp=0/0", lv4, st4); end
  endtask

  task automatic test_reset_mid;
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    sample_in = 8'd240;
    do_reset(1'b1);
    cyc(12);
    checks++; if (lv4 !== 8'd192 || st4 !== 3'd1) begin failures++; $display("FAIL mid_setup got=%0d/%0d exp=192/1", lv4, st4); end
    cyc(1);
    checks++; if (so4 !== 8'd180) begin failures++; $display("FAIL scale_192 got=%0d exp=180", so4); end
    #2 reset = 1'b1;
    #1;
    checks++; if (lv4 !== 8'd0 || st4 !== 3'd0 || so4 !== 8'd0 || ac4 !== 1'b0) begin failures++; $display("FAIL async_abort got=%0d/%0d/%0d/%0d exp=0/0/0/0", lv4, st4, so4, ac4); end
  endtask

  task automatic test_tick1;
    logic [7:0] exp_l [8];
    exp_l = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd223, 8'd191, 8'd159, 8'd128};
    set_params(8'd64, 8'd32, 8'd128, 8'd50);
    do_reset(1'b1);
    cyc(1);
    checks++; if (st1 !== 3'd1 || lv1 !== 8'd0) begin failures++; $display("FAIL t1_rise got=%0d/%0d exp=1/0", st1, lv1); end
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      checks++; if (lv1 !== exp_l[i]) begin failures++; $display("FAIL t1_level_%0d got=%0d exp=%0d", i, lv1, exp_l[i]); end
    end
    checks++; if (st1 !== 3'd3) begin failures++; $display("FAIL t1_sustain got=%0d exp=3", st1); end
  endtask

  initial begin
    test_reset;
    test_attack_decay;
    test_release;
    test_retrigger;
    test_edge_priority;
    test_zero_steps;
    test_reset_mid;
    test_tick1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 Parameter: TICK_DIV, default 1000, clock cycles per envelope tick; legal range 1 to 2^16.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clock is clk.
REQ-004 gate  input  1  note-on level; high = key held.
REQ-005 attack_step  input  8  unsigned level increment per tick in ATTACK.
REQ-006 decay_step  input  8  unsigned level decrement per tick in DECAY.
REQ-007 sustain_level  input  8  unsigned hold level.
REQ-008 release_step  input  8  unsigned level decrement per tick in RELEASE.
REQ-009 sample_in  input  8  unsigned waveform sample from the upstream triangle generator.
REQ-010 sample_out  output  8  registered, envelope-scaled sample.
REQ-011 env_level  output  8  current envelope level, registered.
REQ-012 state  output  3  FSM state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-013 active  output  1  high whenever state != IDLE.

Function
REQ-014 gate shall be registered once (gate_q); rise = gate & ~gate_q, fall = ~gate & gate_q, each a one-cycle pulse.
REQ-015 Tick counter shall run freely from 0 to TICK_DIV-1 and wrap; tick is high in the cycle where the count equals TICK_DIV-1; for TICK_DIV=1, tick is high every cycle.
REQ-016 Gate edges shall act on the next clock edge regardless of tick, and shall take priority over any tick-driven update in the same cycle.
REQ-017 rise from any state shall go to ATTACK, keeping env_level unchanged (retrigger from current level, no reset to 0).
REQ-018 fall in ATTACK, DECAY or SUSTAIN shall go to RELEASE, keeping env_level; fall in IDLE or RELEASE shall have no effect.
REQ-019 IDLE: env_level shall be held at 0.
REQ-020 ATTACK, on tick: if env_level + attack_step >= 255 (computed 9-bit) or attack_step == 0, env_level <= 255 and state <= DECAY; else env_level <= env_level + attack_step.
REQ-021 DECAY, on tick: if env_level <= sustain_level + decay_step (9-bit compare) or decay_step == 0, env_level <= sustain_level and state <= SUSTAIN; else env_level <= env_level - decay_step.
REQ-022 SUSTAIN: on each tick, env_level <= sustain_level, so live changes track at tick rate; the FSM remains in SUSTAIN while gate is high.
REQ-023 RELEASE, on tick: if env_level <= release_step or release_step == 0, env_level <= 0 and state <= IDLE; else env_level <= env_level - release_step.
REQ-024 No arithmetic shall wrap; all clamping follows REQ-020 to REQ-023.
REQ-025 sample_out shall equal bits [15:8] of the 16-bit unsigned product sample_in * env_level, using the registered env_level value, with one clock of latency; env_level=255 yields sample_in - 1 for nonzero sample_in.
REQ-026 Step and sustain inputs shall be sampled at the tick on which they are used; no input latching.

Reset
REQ-027 While reset is high: state=IDLE, env_level=0, sample_out=0, active=0, tick counter=0, gate_q=0.
REQ-028 On reset deassertion with gate already high, the first clock edge shall see rise and enter ATTACK.
REQ-029 Reset asserted mid-envelope shall abort immediately to the REQ-027 values, with no release phase.

Verification (TICK_DIV=4 unless stated)
REQ-030 Attack: attack_step=64, decay_step=32, sustain_level=128, gate high -> env_level 64,128,192,255 on successive ticks, state then DECAY; next tick 223, then 191, 159, 128 (clamped), state SUSTAIN.
REQ-031 Release: from SUSTAIN at 128, release_step=50, drop gate -> RELEASE next cycle; ticks give 78, 28, 0; state IDLE, active=0.
REQ-032 Retrigger: gate re-raised during RELEASE at level 78 with attack_step=100 -> ATTACK, then 178, then 255 and DECAY.
REQ-033 Scaling: env_level=128, sample_in=240 -> sample_out=120 one cycle later; env_level=0 -> 0; env_level=255, sample_in=240 -> 239.
REQ-034 Zero steps: attack_step=0 -> 255 at the first tick; decay_step=0 -> sustain at the next tick; release_step=0 -> 0 at the next tick.
REQ-035 Reset mid-ATTACK at level 192 -> env_level=0, state=0, sample_out=0 asynchronously; TICK_DIV=1 run of REQ-030 gives the same level sequence on consecutive cycles.
